main_vga_test: RTL and testbench

- 640x480 at 60 Hz VGA test-pattern generator for a 50 MHz board clock driving an ADV7123-style video DAC.
- The screen is split into four equal quadrants, each filled with a palette colour.
- A debounced push-button (cuadrante) selects the active quadrant. The selected quadrant's colour steps through the palette once per frame.
- reset_color restores the default palette.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_sync_gen.sv | 69 ++++++
 rtl/main_vga_test.sv | 116 +++++++++++
 tb/tb_main_vga_test.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour types and the test-pattern palette.
package vga_pkg;

  localparam int H_VIS_DEF = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VIS_DEF + H_FP + H_SYNC + H_BP;

  localparam int V_VIS_DEF = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VIS_DEF + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  // Index order: black, red, green, blue, yellow, cyan, magenta, white
  localparam rgb24_t PALETTE [8] = '{
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'hFF, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'hFF},
    '{r: 8'hFF, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'hFF, b: 8'hFF}
  };

  localparam logic [3:0][2:0] PAL_DEFAULT = {3'd3, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-enable divider, h/v counters and registered hsync/vsync/n_blanc.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VIS_DEF,
  parameter int V_VIS = V_VIS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_end,
  output logic       hsync,
  output logic       vsync,
  output logic       n_blanc
);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - H_VIS_DEF + H_VIS - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - V_VIS_DEF + V_VIS - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic       pix_q   = 1'b0;
  logic [9:0] hcount  = '0;
  logic [9:0] vcount  = '0;
  logic       hs_q    = 1'b0;
  logic       vs_q    = 1'b0;
  logic       blank_q = 1'b0;

  assign active    = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
  assign frame_end = pix_q && (hcount == '0) && (vcount == 10'(V_VIS));

  // Sync/blank are sampled from the counters every clk so they line up with the rgb register
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q   <= 1'b0;
      hcount  <= '0;
      vcount  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      pix_q <= ~pix_q;
      if (pix_q) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
      hs_q    <= !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
      vs_q    <= !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
      blank_q <= active;
    end
  end

  assign pix_en  = pix_q;
  assign x       = hcount;
  assign y       = vcount;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign n_blanc = blank_q;

endmodule

// File: rtl/main_vga_test.sv
// VGA four-quadrant test pattern; a debounced button picks the quadrant whose colour cycles per frame.
// Define BORDER_HIGHLIGHT_EN to outline the selected quadrant's inner edges in white.
module main_vga_test
  import vga_pkg::*;
#(
  parameter int H_VIS           = H_VIS_DEF,
  parameter int V_VIS           = V_VIS_DEF,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_color,
  input  logic       cuadrante,
  output logic       hsync,
  output logic       vsync,
  output logic       n_sync,
  output logic       n_blanc,
  output logic       n25MHZCLK,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [2:0] cuadrante_actual
);

  localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [9:0]     H_HALF  = 10'(H_VIS / 2);
  localparam logic [9:0]     V_HALF  = 10'(V_VIS / 2);

  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       frame_end;

  logic [DW-1:0]   deb_cnt = '0;
  quad_t           quad    = Q0;
  logic [3:0][2:0] pal_idx = '0;
  rgb24_t          rgb_q   = '0;

  quad_t  pix_quad;
  rgb24_t pixel;

  vga_sync_gen #(
    .H_VIS (H_VIS),
    .V_VIS (V_VIS)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .x         (x),
    .y         (y),
    .active    (active),
    .frame_end (frame_end),
    .hsync     (hsync),
    .vsync     (vsync),
    .n_blanc   (n_blanc)
  );

  // Counter saturates at DEB_MAX so a held button advances the quadrant exactly once
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      quad    <= Q0;
    end else if (!cuadrante) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + 1'b1;
      if (deb_cnt == DEB_MAX - 1'b1)
        quad <= quad_t'(2'(quad + 2'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reset_color)
      pal_idx <= PAL_DEFAULT;
    else if (frame_end)
      pal_idx[quad] <= pal_idx[quad] + 3'd1;
  end

`ifdef BORDER_HIGHLIGHT_EN
  localparam logic [9:0] BORDER_W = 10'd4;
  logic on_x_edge;
  logic on_y_edge;

  assign on_x_edge = (x >= H_HALF) ? (x < H_HALF + BORDER_W) : (x >= H_HALF - BORDER_W);
  assign on_y_edge = (y >= V_HALF) ? (y < V_HALF + BORDER_W) : (y >= V_HALF - BORDER_W);

  always_comb begin
    pix_quad = quad_t'({y >= V_HALF, x >= H_HALF});
    pixel    = PALETTE[pal_idx[pix_quad]];
    if ((pix_quad == quad) && (on_x_edge || on_y_edge))
      pixel = PALETTE[7];
  end
`else
  always_comb begin
    pix_quad = quad_t'({y >= V_HALF, x >= H_HALF});
    pixel    = PALETTE[pal_idx[pix_quad]];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)
      rgb_q <= '0;
    else
      rgb_q <= active ? pixel : '0;
  end

  assign r                = rgb_q.r;
  assign g                = rgb_q.g;
  assign b                = rgb_q.b;
  assign n_sync           = 1'b0;
  assign n25MHZCLK        = pix_en;
  assign cuadrante_actual = {1'b0, quad};

endmodule

// File: tb/tb_main_vga_test.sv
// Directed bench for main_vga_test on a scaled 16x8 visible area (porches/sync unchanged) so frames stay short.
module tb_main_vga_test;

  localparam int H_VIS  = 16;
  localparam int V_VIS  = 8;
  localparam int HT     = 16 + 16 + 96 + 48;
  localparam int VT     = 8 + 10 + 2 + 33;
  localparam int FRAME  = HT * VT;
  localparam int HS_AT  = 32;
  localparam int VS_ROW = 18;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset_color = 1'b0;
  logic       cuadrante = 1'b0;
  logic       hsync, vsync, n_sync, n_blanc, n25MHZCLK;
  logic [7:0] r, g, b;
  logic [2:0] cuadrante_actual;

  int checks = 0;
  int errors = 0;
  int edge_k = 0;

  typedef struct packed {
    logic [7:0]  f;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
    logic        nb;
  } pix_t;

  main_vga_test #(
    .H_VIS           (H_VIS),
    .V_VIS           (V_VIS),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .reset_color      (reset_color),
    .cuadrante        (cuadrante),
    .hsync            (hsync),
    .vsync            (vsync),
    .n_sync           (n_sync),
    .n_blanc          (n_blanc),
    .n25MHZCLK        (n25MHZCLK),
    .r                (r),
    .g                (g),
    .b                (b),
    .cuadrante_actual (cuadrante_actual)
  );

  always #10 clk = ~clk;

  // After edge k (counted from the first edge with reset low) the outputs show pixel (k-1)/2
  always @(posedge clk) begin
    if (reset) edge_k <= 0;
    else       edge_k <= edge_k + 1;
  end

  task automatic goto_pixel(input int f, input int x, input int y);
    int target;
    target = 2 * (f * FRAME + y * HT + x) + 1;
    if (edge_k > target) begin
      checks++; errors++;
      $display("[TB] FAIL goto_pixel: edge %0d already past required %0d", edge_k, target);
    end
    while (edge_k < target) @(negedge clk);
  endtask

  task automatic hold_button(input int n);
    @(negedge clk) cuadrante = 1'b1;
    repeat (n) @(negedge clk);
    cuadrante = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_powerup();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      checks++;
      if (cuadrante_actual !== 3'd0) begin
        errors++; $display("[TB] FAIL powerup_quad: got %b expected 000 (iter %0d)", cuadrante_actual, i);
      end
      cuadrante = 1'b1;
      reset_color = (i == 1250);
      @(posedge clk); #1;
      checks++;
      if (cuadrante_actual !== 3'd0) begin
        errors++; $display("[TB] FAIL powerup_quad: got %b expected 000 (iter %0d)", cuadrante_actual, i);
      end
      @(negedge clk);
      cuadrante = 1'b0;
      reset_color = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cuadrante_actual !== 3'd0) begin
        errors++; $display("[TB] FAIL powerup_quad: got %b expected 000 (iter %0d)", cuadrante_actual, i);
      end
    end
  endtask

  task automatic test_reset();
    hold_button(4);
    checks++;
    if (cuadrante_actual !== 3'd1) begin
      errors++; $display("[TB] FAIL pre_reset_quad: got %b expected 001", cuadrante_actual);
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({hsync, vsync, n_blanc, n25MHZCLK, n_sync} !== 5'b11000) begin
      errors++; $display("[TB] FAIL reset_sync: got %b expected 11000", {hsync, vsync, n_blanc, n25MHZCLK, n_sync});
    end
    checks++;
    if ({r, g, b} !== 24'h000000) begin
      errors++; $display("[TB] FAIL reset_rgb: got %h expected 000000", {r, g, b});
    end
    checks++;
    if (cuadrante_actual !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_quad: got %b expected 000", cuadrante_actual);
    end
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    logic [2:0] exp_q [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 4; i++) begin
      hold_button(4);
      checks++;
      if (cuadrante_actual !== exp_q[i]) begin
        errors++; $display("[TB] FAIL press4_%0d: got %b expected %b", i, cuadrante_actual, exp_q[i]);
      end
    end
    hold_button(3);
    checks++;
    if (cuadrante_actual !== 3'd0) begin
      errors++; $display("[TB] FAIL press3: got %b expected 000", cuadrante_actual);
    end
    @(negedge clk) cuadrante = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (cuadrante_actual !== 3'd1) begin
      errors++; $display("[TB] FAIL hold_first_advance: got %b expected 001", cuadrante_actual);
    end
    repeat (96) @(negedge clk);
    cuadrante = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cuadrante_actual !== 3'd1) begin
      errors++; $display("[TB] FAIL hold100: got %b expected 001", cuadrante_actual);
    end
  endtask

  task automatic test_palette();
    pix_t tbl [13] = '{
      '{f: 0, x: 2,  y: 1, rgb: 24'h000000, nb: 1'b1},
      '{f: 0, x: 12, y: 1, rgb: 24'hFF0000, nb: 1'b1},
      '{f: 0, x: 7,  y: 3, rgb: 24'h000000, nb: 1'b1},
      '{f: 0, x: 8,  y: 3, rgb: 24'hFF0000, nb: 1'b1},
      '{f: 0, x: 16, y: 3, rgb: 24'h000000, nb: 1'b0},
      '{f: 0, x: 7,  y: 4, rgb: 24'h00FF00, nb: 1'b1},
      '{f: 0, x: 2,  y: 6, rgb: 24'h00FF00, nb: 1'b1},
      '{f: 0, x: 12, y: 6, rgb: 24'h0000FF, nb: 1'b1},
      '{f: 0, x: 15, y: 7, rgb: 24'h0000FF, nb: 1'b1},
      '{f: 0, x: 0,  y: 8, rgb: 24'h000000, nb: 1'b0},
      '{f: 1, x: 2,  y: 1, rgb: 24'hFF0000, nb: 1'b1},
      '{f: 1, x: 12, y: 1, rgb: 24'hFF0000, nb: 1'b1},
      '{f: 1, x: 2,  y: 6, rgb: 24'h00FF00, nb: 1'b1}
    };
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      goto_pixel(int'(tbl[i].f), int'(tbl[i].x), int'(tbl[i].y));
      checks++;
      if ({r, g, b} !== tbl[i].rgb) begin
        errors++; $display("[TB] FAIL palette_rgb f%0d (%0d,%0d): got %h expected %h",
                           tbl[i].f, tbl[i].x, tbl[i].y, {r, g, b}, tbl[i].rgb);
      end
      checks++;
      if (n_blanc !== tbl[i].nb) begin
        errors++; $display("[TB] FAIL palette_blank f%0d (%0d,%0d): got %b expected %b",
                           tbl[i].f, tbl[i].x, tbl[i].y, n_blanc, tbl[i].nb);
      end
    end
  endtask

  task automatic test_hsync();
    int w, low, high;
    w = 0;
    while (hsync !== 1'b1 && w < 4 * HT) begin @(negedge clk); w++; end
    w = 0;
    while (hsync !== 1'b0 && w < 4 * HT) begin @(negedge clk); w++; end
    checks++;
    if (hsync !== 1'b0) begin
      errors++; $display("[TB] FAIL hsync_timeout: got %b expected 0 within %0d clk", hsync, 4 * HT);
      return;
    end
    checks++;
    if (((edge_k - 1) / 2) % HT != HS_AT) begin
      errors++; $display("[TB] FAIL hsync_position: got hcount %0d expected %0d", ((edge_k - 1) / 2) % HT, HS_AT);
    end
    low = 0;
    while (hsync === 1'b0 && low < 4 * HT) begin @(negedge clk); low++; end
    high = 0;
    while (hsync === 1'b1 && high < 4 * HT) begin @(negedge clk); high++; end
    checks++;
    if (low != 192) begin
      errors++; $display("[TB] FAIL hsync_width: got %0d clk expected 192", low);
    end
    checks++;
    if (low + high != 2 * HT) begin
      errors++; $display("[TB] FAIL hsync_period: got %0d clk expected %0d", low + high, 2 * HT);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n25MHZCLK !== 1'(edge_k % 2)) begin
        errors++; $display("[TB] FAIL pixclk: got %b expected %b at edge %0d", n25MHZCLK, 1'(edge_k % 2), edge_k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_vsync();
    int w, low, high;
    w = 0;
    while (vsync !== 1'b1 && w < 4 * FRAME) begin @(negedge clk); w++; end
    w = 0;
    while (vsync !== 1'b0 && w < 4 * FRAME) begin @(negedge clk); w++; end
    checks++;
    if (vsync !== 1'b0) begin
      errors++; $display("[TB] FAIL vsync_timeout: got %b expected 0 within %0d clk", vsync, 4 * FRAME);
      return;
    end
    checks++;
    if (((edge_k - 1) / 2) % FRAME != VS_ROW * HT) begin
      errors++; $display("[TB] FAIL vsync_position: got pixel %0d expected %0d", ((edge_k - 1) / 2) % FRAME, VS_ROW * HT);
    end
    low = 0;
    while (vsync === 1'b0 && low < 4 * FRAME) begin @(negedge clk); low++; end
    high = 0;
    while (vsync === 1'b1 && high < 4 * FRAME) begin @(negedge clk); high++; end
    checks++;
    if (low != 4 * HT) begin
      errors++; $display("[TB] FAIL vsync_width: got %0d clk expected %0d", low, 4 * HT);
    end
    checks++;
    if (low + high != 2 * FRAME) begin
      errors++; $display("[TB] FAIL vsync_period: got %0d clk expected %0d", low + high, 2 * FRAME);
    end
  endtask

  task automatic test_reset_color();
    // Q0 has stepped to index 3 by now, so defaults in frame 3 can only come from reset_color
    pix_t tbl [5] = '{
      '{f: 3, x: 2,   y: 1, rgb: 24'h000000, nb: 1'b1},
      '{f: 3, x: 12,  y: 1, rgb: 24'hFF0000, nb: 1'b1},
      '{f: 3, x: 100, y: 1, rgb: 24'h000000, nb: 1'b0},
      '{f: 3, x: 2,   y: 6, rgb: 24'h00FF00, nb: 1'b1},
      '{f: 3, x: 12,  y: 6, rgb: 24'h0000FF, nb: 1'b1}
    };
    @(negedge clk) reset_color = 1'b1;
    @(negedge clk) reset_color = 1'b0;
    for (int i = 0; i < 5; i++) begin
      goto_pixel(int'(tbl[i].f), int'(tbl[i].x), int'(tbl[i].y));
      checks++;
      if ({r, g, b} !== tbl[i].rgb) begin
        errors++; $display("[TB] FAIL rstcolor_rgb (%0d,%0d): got %h expected %h",
                           tbl[i].x, tbl[i].y, {r, g, b}, tbl[i].rgb);
      end
      checks++;
      if (n_blanc !== tbl[i].nb) begin
        errors++; $display("[TB] FAIL rstcolor_blank (%0d,%0d): got %b expected %b",
                           tbl[i].x, tbl[i].y, n_blanc, tbl[i].nb);
      end
    end
    checks++;
    if (cuadrante_actual !== 3'd0) begin
      errors++; $display("[TB] FAIL rstcolor_quad: got %b expected 000", cuadrante_actual);
    end
  endtask

  initial begin
    $display("[TB] starting main_vga_test bench");
    test_powerup();
    test_reset();
    test_debounce();
    test_palette();
    test_hsync();
    test_vsync();
    test_reset_color();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
